// File: rtl/branch_sequencer_if.sv
// Signal bundle between the branch sequencer and its datapath/control host.
// The host drives start/ir/con; the sequencer drives the control enables, status and statistics.
interface branch_sequencer_if;
  logic        start;
  logic [31:0] ir;
  logic        con;
  logic [1:0]  cond_code;
  logic        gra;
  logic        r_out;
  logic        con_in;
  logic        pc_out;
  logic        y_in;
  logic        c_out;
  logic        add_op;
  logic        z_in;
  logic        zlow_out;
  logic        pc_in;
  logic        busy;
  logic        done;
  logic        taken;
  logic        err;
  logic [15:0] taken_count;
  logic [15:0] not_taken_count;

  modport master (
    output start, ir, con,
    input  cond_code, gra, r_out, con_in, pc_out, y_in, c_out, add_op, z_in, zlow_out, pc_in,
    input  busy, done, taken, err, taken_count, not_taken_count
  );

  modport slave (
    input  start, ir, con,
    output cond_code, gra, r_out, con_in, pc_out, y_in, c_out, add_op, z_in, zlow_out, pc_in,
    output busy, done, taken, err, taken_count, not_taken_count
  );
endinterface

// File: rtl/branch_sequencer.sv
// Control sequencer for a conditional branch: COND -> PCY -> ADD -> UPD, then done.
// Define BRANCH_STATS_EN to build the saturating taken/not-taken counters.
module branch_sequencer #(
  parameter logic [4:0] OPCODE_BR = 5'b10010
) (
  input  logic         clock,
  input  logic         reset,
  branch_sequencer_if.slave bus
);

  typedef enum logic [2:0] {StIdle, StCond, StPcy, StAdd, StUpd} state_e;

  state_e      state_q, state_d;
  logic [1:0]  cond_code_q;
  logic        con_q;
  logic        taken_q;
  logic        done_q;
  logic        err_q;
  logic        is_br;
  logic        accept;
  logic        reject;

  logic unused_ir;
  assign unused_ir = ^{bus.ir[26:21], bus.ir[18:0]};

  assign is_br  = (bus.ir[31:27] == OPCODE_BR);
  assign accept = (state_q == StIdle) && bus.start && is_br;
  assign reject = (state_q == StIdle) && bus.start && !is_br;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = StCond;
      StCond:  state_d = StPcy;
      StPcy:   state_d = StAdd;
      StAdd:   state_d = StUpd;
      StUpd:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= StIdle;
      cond_code_q <= 2'b00;
      con_q       <= 1'b0;
      taken_q     <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= (state_q == StUpd);
      err_q   <= reject;
      if (accept)             cond_code_q <= bus.ir[20:19];
      if (state_q == StCond)  con_q       <= bus.con;
      if (state_q == StUpd)   taken_q     <= con_q;
    end
  end

  // Enables are a pure decode of the state so nothing leaks through from start or con.
  always_comb begin
    bus.gra      = 1'b0;
    bus.r_out    = 1'b0;
    bus.con_in   = 1'b0;
    bus.pc_out   = 1'b0;
    bus.y_in     = 1'b0;
    bus.c_out    = 1'b0;
    bus.add_op   = 1'b0;
    bus.z_in     = 1'b0;
    bus.zlow_out = 1'b0;
    bus.pc_in    = 1'b0;
    unique case (state_q)
      StCond: begin
        bus.gra    = 1'b1;
        bus.r_out  = 1'b1;
        bus.con_in = 1'b1;
      end
      StPcy: begin
        bus.pc_out = 1'b1;
        bus.y_in   = 1'b1;
      end
      StAdd: begin
        bus.c_out  = 1'b1;
        bus.add_op = 1'b1;
        bus.z_in   = 1'b1;
      end
      StUpd: begin
        bus.zlow_out = 1'b1;
        bus.pc_in    = con_q;
      end
      default: ;
    endcase
  end

  assign bus.busy      = (state_q != StIdle);
  assign bus.cond_code = cond_code_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.taken     = taken_q;

`ifdef BRANCH_STATS_EN
  logic [15:0] taken_cnt_q;
  logic [15:0] not_taken_cnt_q;

  // Counters move on the same edge that raises done, so they are current while done is high.
  always_ff @(posedge clock) begin
    if (reset) begin
      taken_cnt_q     <= 16'h0000;
      not_taken_cnt_q <= 16'h0000;
    end else if (state_q == StUpd) begin
      if (con_q) begin
        if (taken_cnt_q != 16'hFFFF) taken_cnt_q <= taken_cnt_q + 16'd1;
      end else begin
        if (not_taken_cnt_q != 16'hFFFF) not_taken_cnt_q <= not_taken_cnt_q + 16'd1;
      end
    end
  end

  assign bus.taken_count     = taken_cnt_q;
  assign bus.not_taken_count = not_taken_cnt_q;
`else
  assign bus.taken_count     = 16'h0000;
  assign bus.not_taken_count = 16'h0000;
`endif

endmodule

// File: doc/branch_sequencer.md
BRANCH_SEQUENCER -- requirements
Module: branch_sequencer

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, with ports named clock and reset.
REQ-002 Parameter OPCODE_BR SHALL default to 5'b10010 and SHALL be the IR[31:27] value identifying a conditional branch.
REQ-003 Port list SHALL be as follows (name, direction, width, meaning):
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous active-high reset.
- start  in  1  request to execute the instruction in ir.
- ir  in  32  instruction register contents.
- con  in  1  combinational branch-condition result from the condition evaluator.
- cond_code  out  2  latched IR[20:19] presented to the condition evaluator.
- gra, r_out, con_in  out  1 each  register-select, register-to-bus, condition-latch enables.
- pc_out, y_in  out  1 each  PC-to-bus, Y-register load.
- c_out, add_op, z_in  out  1 each  sign-extended C to bus, ALU add, Z load.
- zlow_out, pc_in  out  1 each  Zlow-to-bus, PC load.
- busy  out  1  sequence in progress.
- done  out  1  one-cycle completion pulse.
- taken  out  1  result of the last completed branch.
- err  out  1  one-cycle pulse: start with a non-branch opcode.
- taken_count, not_taken_count  out  16 each  statistics (see Configuration).

Function
REQ-010 States SHALL be IDLE, COND, PCY, ADD, UPD; encoding is free.
REQ-011 In IDLE with start=1 and ir[31:27]==OPCODE_BR, the block SHALL latch ir[20:19] into cond_code and go to COND next cycle.
REQ-012 In IDLE with start=1 and ir[31:27]!=OPCODE_BR, the block SHALL pulse err for exactly the next cycle, stay in IDLE, and leave cond_code and taken unchanged.
REQ-013 start SHALL be ignored whenever the state is not IDLE.
REQ-014 In COND, gra, r_out and con_in SHALL be 1; con SHALL be sampled into internal con_q at the end of this cycle.
REQ-015 In PCY, pc_out and y_in SHALL be 1.
REQ-016 In ADD, c_out, add_op and z_in SHALL be 1.
REQ-017 In UPD, zlow_out SHALL be 1; pc_in SHALL equal con_q.
REQ-018 On leaving UPD, the block SHALL return to IDLE, pulse done for one cycle, and set taken to con_q.
REQ-019 Latency SHALL be fixed: done asserts exactly 5 cycles after the accepting start edge.
REQ-020 busy SHALL be 1 in COND, PCY, ADD and UPD, and 0 in IDLE.
REQ-021 At most one control enable group SHALL be active per cycle; all enables SHALL be 0 in IDLE.
REQ-022 All outputs SHALL be registered or decoded solely from state; no output SHALL depend combinationally on start or con.
REQ-023 A start in the same cycle as done SHALL be accepted, allowing back-to-back branches with no bubble beyond IDLE.

Reset
REQ-030 reset=1 at a rising edge SHALL force IDLE and clear con_q, cond_code, taken, done, err and every enable to 0, including mid-sequence.
REQ-031 A sequence interrupted by reset SHALL NOT produce done, pc_in or a statistics update.
REQ-032 reset SHALL take priority over start in the same cycle.

Configuration
REQ-040 Macro BRANCH_STATS_EN SHALL control the statistics feature.
REQ-041 With BRANCH_STATS_EN defined: on each done, taken_count SHALL increment if con_q=1, else not_taken_count SHALL increment; both counters SHALL saturate at 16'hFFFF and clear on reset.
REQ-042 Without BRANCH_STATS_EN: both counters SHALL be tied to 16'h0000 and no counter flops SHALL be synthesized.

Verification
REQ-050 Scenario: ir=32'h9008_0000 (brnz), start=1, con=1 sampled in COND -> pc_in=1 in UPD, done 5 cycles later, taken=1.
REQ-051 Scenario: same ir, con=0 -> zlow_out=1 and pc_in=0 in UPD, taken=0, done still at cycle 5.
REQ-052 Scenario: ir=32'h0800_0000 (non-branch), start=1 -> err pulse next cycle, busy stays 0, no enables asserted.
REQ-053 Scenario: reset asserted in PCY -> IDLE next cycle, all outputs 0, no done.
REQ-054 Scenario: start held high across two branches -> second accepted on the done cycle, cond_code updated, two done pulses 5 cycles apart.
REQ-055 Scenario (BRANCH_STATS_EN): 3 taken + 2 not-taken branches -> taken_count=3, not_taken_count=2; without the macro both read 0.
